// File: rtl/fpmul.sv
`default_nettype none
// fpmul: multi-cycle IEEE-754 single-precision multiplier.
// Denormals are flushed to zero and the result is rounded to nearest, ties to even.
module fpmul (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Done,
  output logic [31:0] P,
  output logic        OF,
  output logic        UF,
  output logic        NaNF,
  output logic        InfF,
  output logic        DNF,
  output logic        ZF
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    MULT   = 3'd2,
    NORM   = 3'd3,
    ROUND  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t             state_q;
  logic [31:0]        a_q, b_q;
  logic               sign_q, nan_q, inf_q, zero_q, dn_q;
  logic [23:0]        ma_q, mb_q;
  logic [7:0]         ea_q, eb_q;
  logic [47:0]        prod_q;
  logic signed [9:0]  exp_q;
  logic [23:0]        mant_q;
  logic               grd_q, rnd_q, stk_q;
  logic               done_q, of_q, uf_q, nanf_q, inff_q, dnf_q, zf_q;
  logic [31:0]        p_q;

  // Operand classification
  logic a_emax, b_emax, a_ezero, b_ezero, a_fnz, b_fnz;
  logic nan_d, inf_d, zero_d, dn_d;
  assign a_emax  = &a_q[30:23];
  assign b_emax  = &b_q[30:23];
  assign a_ezero = ~|a_q[30:23];
  assign b_ezero = ~|b_q[30:23];
  assign a_fnz   = |a_q[22:0];
  assign b_fnz   = |b_q[22:0];
  assign zero_d  = a_ezero | b_ezero;
  assign inf_d   = (a_emax & ~a_fnz) | (b_emax & ~b_fnz);
  assign nan_d   = (a_emax & a_fnz) | (b_emax & b_fnz) | (inf_d & zero_d);
  assign dn_d    = (a_ezero & a_fnz) | (b_ezero & b_fnz);

  // Normalization of the 48-bit product into 24-bit mantissa plus G/R/S
  logic [23:0]       nmant_d;
  logic              ngrd_d, nrnd_d, nstk_d;
  logic signed [9:0] nexp_d;
  always_comb begin
    nmant_d = prod_q[46:23];
    ngrd_d  = prod_q[22];
    nrnd_d  = prod_q[21];
    nstk_d  = |prod_q[20:0];
    nexp_d  = exp_q;
    if (prod_q[47]) begin
      nmant_d = prod_q[47:24];
      ngrd_d  = prod_q[23];
      nrnd_d  = prod_q[22];
      nstk_d  = |prod_q[21:0];
      nexp_d  = exp_q + 10'sd1;
    end
  end

  // Round-to-nearest-even; a carry out renormalizes to 1.0 x 2^(e+1)
  logic              rup_d;
  logic [24:0]       sum_d;
  logic signed [9:0] efin_d;
  logic [22:0]       frac_d;
  assign rup_d  = grd_q & (rnd_q | stk_q | mant_q[0]);
  assign sum_d  = {1'b0, mant_q} + {24'd0, rup_d};
  assign efin_d = sum_d[24] ? exp_q + 10'sd1 : exp_q;
  assign frac_d = sum_d[24] ? sum_d[23:1] : sum_d[22:0];

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      nan_q   <= 1'b0;
      inf_q   <= 1'b0;
      zero_q  <= 1'b0;
      dn_q    <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
      ea_q    <= '0;
      eb_q    <= '0;
      prod_q  <= '0;
      exp_q   <= '0;
      mant_q  <= '0;
      grd_q   <= 1'b0;
      rnd_q   <= 1'b0;
      stk_q   <= 1'b0;
      done_q  <= 1'b0;
      p_q     <= '0;
      of_q    <= 1'b0;
      uf_q    <= 1'b0;
      nanf_q  <= 1'b0;
      inff_q  <= 1'b0;
      dnf_q   <= 1'b0;
      zf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (Start) begin
            a_q     <= A;
            b_q     <= B;
            done_q  <= 1'b0;
            state_q <= UNPACK;
          end
        end
        UNPACK: begin
          sign_q  <= a_q[31] ^ b_q[31];
          nan_q   <= nan_d;
          inf_q   <= inf_d;
          zero_q  <= zero_d;
          dn_q    <= dn_d;
          ma_q    <= {1'b1, a_q[22:0]};
          mb_q    <= {1'b1, b_q[22:0]};
          ea_q    <= a_q[30:23];
          eb_q    <= b_q[30:23];
          state_q <= MULT;
        end
        MULT: begin
          prod_q  <= {24'd0, ma_q} * {24'd0, mb_q};
          exp_q   <= $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - 10'sd127;
          state_q <= NORM;
        end
        NORM: begin
          mant_q  <= nmant_d;
          grd_q   <= ngrd_d;
          rnd_q   <= nrnd_d;
          stk_q   <= nstk_d;
          exp_q   <= nexp_d;
          state_q <= ROUND;
        end
        ROUND: begin
          of_q    <= 1'b0;
          uf_q    <= 1'b0;
          nanf_q  <= 1'b0;
          inff_q  <= 1'b0;
          zf_q    <= 1'b0;
          dnf_q   <= dn_q;
          done_q  <= 1'b1;
          state_q <= DONE;
          if (nan_q) begin
            p_q    <= 32'h7FC0_0000;
            nanf_q <= 1'b1;
          end else if (inf_q) begin
            p_q    <= {sign_q, 8'hFF, 23'd0};
            inff_q <= 1'b1;
          end else if (zero_q) begin
            p_q    <= {sign_q, 31'd0};
            zf_q   <= 1'b1;
          end else if (efin_d >= 10'sd255) begin
            p_q    <= {sign_q, 8'hFF, 23'd0};
            of_q   <= 1'b1;
            inff_q <= 1'b1;
          end else if (efin_d <= 10'sd0) begin
            p_q    <= {sign_q, 31'd0};
            uf_q   <= 1'b1;
            zf_q   <= 1'b1;
          end else begin
            p_q    <= {sign_q, efin_d[7:0], frac_d};
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Done = done_q;
  assign P    = p_q;
  assign OF   = of_q;
  assign UF   = uf_q;
  assign NaNF = nanf_q;
  assign InfF = inff_q;
  assign DNF  = dnf_q;
  assign ZF   = zf_q;

endmodule
`default_nettype wire

// File: tb/tb_fpmul.sv
`default_nettype none
// tb_fpmul: table-driven directed vectors plus reset/abort and hold sequences for fpmul.
module tb_fpmul;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Done;
  logic [31:0] P;
  logic        OF, UF, NaNF, InfF, DNF, ZF;

  int errors = 0;
  int checks = 0;

  fpmul dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .A(A), .B(B),
    .Done(Done), .P(P), .OF(OF), .UF(UF), .NaNF(NaNF),
    .InfF(InfF), .DNF(DNF), .ZF(ZF)
  );

  always #5 Clk = ~Clk;

  // flags packed as {OF, UF, NaNF, InfF, DNF, ZF}
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    logic [5:0]  f;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] flags();
    return {26'd0, OF, UF, NaNF, InfF, DNF, ZF};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Issues one Start and waits (bounded) for Done; lat counts edges incl. the Start edge.
  task automatic run(input logic [31:0] a, input logic [31:0] b, input bit scramble,
                     output int lat);
    @(negedge Clk);
    A = a;
    B = b;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    lat = 1;
    chk("done_cleared", {31'd0, Done}, 32'd0);
    if (scramble) begin
      A = 32'h7F80_0000;
      B = 32'h0000_0000;
    end
    while (!Done && lat < 20) begin
      @(posedge Clk);
      #1;
      lat++;
    end
  endtask

  task automatic add(input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] p, input logic [5:0] f);
    vec_t v;
    v.a = a; v.b = b; v.p = p; v.f = f;
    vecs.push_back(v);
  endtask

  initial begin
    int lat;
    string nm;

    add(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 6'b000000);
    add(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 6'b000001);
    add(32'h0000_0009, 32'h0000_0009, 32'h0000_0000, 6'b000011);
    add(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 6'b000000);
    add(32'hBF80_0000, 32'h4040_0000, 32'hC040_0000, 6'b000000);
    add(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 6'b100100);
    add(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 6'b010001);
    add(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 6'b001000);
    add(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 6'b001000);
    add(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 6'b000100);
    add(32'hFF80_0000, 32'h7F80_0000, 32'hFF80_0000, 6'b000100);
    add(32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 6'b000001);
    add(32'h7F80_0000, 32'h0000_0001, 32'h7FC0_0000, 6'b001010);
    add(32'h8000_0005, 32'h4000_0000, 32'h8000_0000, 6'b000011);
    add(32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0002, 6'b000000); // tie, odd lsb: up
    add(32'h3FC0_0000, 32'h3F80_0003, 32'h3FC0_0004, 6'b000000); // tie, even lsb: stay
    add(32'h3FE0_0000, 32'h3F80_0001, 32'h3FE0_0002, 6'b000000); // above half: up
    add(32'h3F91_8E00, 32'h3FE1_2000, 32'h4000_0000, 6'b000000); // rounding carry-out
    add(32'h7F7F_FFFF, 32'h3F80_0000, 32'h7F7F_FFFF, 6'b000000);
    add(32'h0080_0000, 32'h3F80_0000, 32'h0080_0000, 6'b000000);
    add(32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 6'b010001);
    add(32'h8080_0000, 32'h0080_0000, 32'h8000_0000, 6'b010001);
    add(32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000, 6'b100100);
    add(32'h4000_0000, 32'hC000_0000, 32'hC080_0000, 6'b000000);

    // Reset state
    #2 Rst = 1'b1;
    #1;
    chk("reset_done", {31'd0, Done}, 32'd0);
    chk("reset_p", P, 32'd0);
    chk("reset_flags", flags(), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;

    foreach (vecs[i]) begin
      run(vecs[i].a, vecs[i].b, 1'b0, lat);
      nm = $sformatf("vec%0d", i);
      chk({nm, "_latency"}, lat, 32'd5);
      chk({nm, "_p"}, P, vecs[i].p);
      chk({nm, "_flags"}, flags(), {26'd0, vecs[i].f});
    end

    // Every tiny denormal squared flushes to zero
    for (int n = 1; n <= 9; n++) begin
      run(n, n, 1'b0, lat);
      chk($sformatf("dn%0d_p", n), P, 32'd0);
      chk($sformatf("dn%0d_flags", n), flags(), 32'b000011);
    end

    // Operands changed right after the Start edge must not matter
    run(32'h4000_0000, 32'h4000_0000, 1'b1, lat);
    chk("scramble_latency", lat, 32'd5);
    chk("scramble_p", P, 32'h4080_0000);
    chk("scramble_flags", flags(), 32'd0);

    // Done and result hold in DONE while Start stays low
    repeat (4) @(posedge Clk);
    #1;
    chk("hold_done", {31'd0, Done}, 32'd1);
    chk("hold_p", P, 32'h4080_0000);

    // Reset in MULT aborts the operation and clears outputs at once
    run(32'h7F00_0000, 32'h7F00_0000, 1'b0, lat);
    chk("pre_abort_p", P, 32'h7F80_0000);
    @(negedge Clk);
    A = 32'h4000_0000;
    B = 32'h4000_0000;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    @(posedge Clk);
    #2;
    Rst = 1'b1;
    #1;
    chk("abort_done", {31'd0, Done}, 32'd0);
    chk("abort_p", P, 32'd0);
    chk("abort_flags", flags(), 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
    chk("abort_no_done", {31'd0, Done}, 32'd0);
    run(32'h4000_0000, 32'h4000_0000, 1'b0, lat);
    chk("post_abort_latency", lat, 32'd5);
    chk("post_abort_p", P, 32'h4080_0000);
    chk("post_abort_flags", flags(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
